spi_target_interface: RTL and testbench
=======================================

# spi_target_interface

SPI target (slave) endpoint for SPI mode 3 (CPOL = 1, CPHA = 1), the counterpart of the team's SPI master block. It oversamples the external scl/cs/mosi pins in the system clock domain, deserialises mosi into bytes, and serialises a user-supplied byte onto miso. It sits between the SPI pins and the register/bus-side logic, and uses a one-cycle pulse handshake on each side.

## Interface
- SYNC_STAGES, 2: synchroniser depth for scl, cs and mosi (≥ 2).
- clk  in  1  system clock; must run ≥ 8× the scl frequency.
- arstn  in  1  reset; asynchronous, active-low.
- scl  in  1  SPI clock from the master; idles high.
- cs  in  1  chip select, active-low.
- mosi  in  1  serial data from the master.
- miso  out  1  serial data to the master.
- miso_oe  out  1  miso output enable; 1 while a transaction is active.
- tx_byte  in  8  byte to transmit; must be stable whenever tx_latched may pulse.
- tx_latched  out  1  one-cycle pulse: tx_byte was copied into the shift register; the next byte may now be presented.
- rx_byte  out  8  last complete received byte; held until the next complete byte.
- rx_valid  out  1  one-cycle pulse: rx_byte was updated this cycle.
- msb_lsb  in  1  bit order: 1 = MSB first, 0 = LSB first; sampled at each byte latch.
- busy  out  1  1 while the synchronised cs is low.

## Operation
- Each pin passes through SYNC_STAGES flops. scl and cs then go through a registered previous-value flop; their rising and falling edges are decoded from the synchronised and previous values.
- FSM states: IDLE and SHIFT.
  - IDLE → SHIFT on a cs falling edge. On that cycle: tx_byte and msb_lsb are latched, tx_latched pulses, and the bit counter clears.
  - SHIFT → IDLE on a cs rising edge, from any bit position.
- In SHIFT:
  - On an scl falling edge, miso takes the next tx bit: tx[7−n] if MSB first, tx[n] if LSB first, where n = bits already driven.
  - On an scl rising edge, the synchronised mosi is written into the rx shift register at the matching position, and the 3-bit counter increments.
  - After the 8th rising edge (counter wraps 7 → 0), on the same cycle: rx_byte is updated, rx_valid pulses, tx_byte and msb_lsb are re-latched, and tx_latched pulses. The next byte continues with cs still low.
- An scl falling edge also drives the first miso bit of a new byte. miso holds the last driven bit until the next falling edge.
- In IDLE, all scl activity is ignored.
- Aborted byte (cs rises mid-byte): partial data is discarded, with no rx_valid and no tx_latched. The counter clears, and miso returns to 0.
- If a cs rising edge arrives on the same cycle as an scl edge, the cs rise has priority and the scl edge is ignored.
- Reset values: miso 0, miso_oe 0, busy 0, rx_byte 0x00, rx_valid 0, tx_latched 0, FSM IDLE, counter 0, shift registers 0.
- Reset mid-transaction returns every register to its reset value at once. After arstn releases, the block waits for a fresh cs falling edge.

## Timing
- Pin-to-edge-detect latency: SYNC_STAGES + 1 clk cycles (3 with the default).
- miso is updated SYNC_STAGES + 1 clk cycles after the scl falling edge at the pin. This is valid before the next rising edge provided the scl half-period is ≥ 4 clk cycles.
- mosi is sampled through the same synchroniser depth as scl, so pin alignment is preserved.
- rx_valid and tx_latched are single-cycle pulses and coincide at each byte boundary.
- The bus side has one byte period (8 scl periods) to present the next tx_byte.
- miso_oe equals busy, and both are registered.

## Structure
- Package spi_pkg holds:
  - the FSM typedef (IDLE, SHIFT);
  - the SPI mode constants (CPOL = 1, CPHA = 1);
  - the byte-width constant (8).
- The package is shared with the master block.
- Sub-module sync_edge_detect (parameter STAGES; outputs level, rise, fall) is instantiated for scl and cs. mosi uses the level output only.

## Test plan
- MSB first, master sends 0xA5 and tx_byte = 0x3C → rx_byte = 0xA5 with one rx_valid pulse; the master receives 0x3C; tx_latched pulses at the cs fall and at the byte end.
- LSB first (msb_lsb = 0), master sends 0x01 and tx_byte = 0x80 → rx_byte = 0x01; the master sees miso bits 0,0,0,0,0,0,0,1 in time order.
- Two back-to-back bytes in one cs window, 0x12 then 0x34, with tx_byte changed to 0x56 after the first tx_latched → two rx_valid pulses (0x12, 0x34); the second miso byte is 0x56.
- cs raised after 4 scl rising edges → no rx_valid; rx_byte keeps its previous value; miso = 0; the next full transfer of 0xFF is received correctly.
- scl toggling 16 times with cs high → no rx_valid, no tx_latched, busy = 0, miso_oe = 0.
- arstn asserted after 5 bits → all outputs at reset values immediately; a following transfer of 0xC3 completes with rx_byte = 0xC3.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the SPI master and the SPI target.
// Contents: FSM state type, SPI mode constants, byte/counter widths and a helper
// that maps a bit count onto a shift-register index for either bit order.
package spi_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    // SPI mode 3: scl idles high, data is captured on the rising edge.
    localparam logic CPOL = 1'b1;
    localparam logic CPHA = 1'b1;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } spi_state_e;

    // Shift-register index of the n-th bit on the wire.
    function automatic logic [CNT_W-1:0] bit_index(input logic [CNT_W-1:0] n,
                                                   input logic             msb_first);
        return msb_first ? (CNT_W'(BYTE_W - 1) - n) : n;
    endfunction

endpackage

// File: rtl/spi_target_interface_if.sv
// Bus-side handshake of the SPI target.
//   tx_byte/msb_lsb       : byte to send and bit order, driven by the bus side
//   tx_latched            : pulse, tx_byte was copied; the next one may be presented
//   rx_byte/rx_valid      : last received byte and its one-cycle update pulse
//   busy                  : a transaction is in progress
// Modports: master = bus-side logic, slave = the SPI target.
interface spi_target_interface_if;

    logic [spi_pkg::BYTE_W-1:0] tx_byte;
    logic                       msb_lsb;
    logic                       tx_latched;
    logic [spi_pkg::BYTE_W-1:0] rx_byte;
    logic                       rx_valid;
    logic                       busy;

    modport master (
        output tx_byte,
        output msb_lsb,
        input  tx_latched,
        input  rx_byte,
        input  rx_valid,
        input  busy
    );

    modport slave (
        input  tx_byte,
        input  msb_lsb,
        output tx_latched,
        output rx_byte,
        output rx_valid,
        output busy
    );

endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser followed by a previous-value flop for edge decode.
//   clk, arstn : system clock, asynchronous active-low reset
//   d          : asynchronous input pin
//   level      : synchronised value (STAGES cycles behind the pin)
//   rise/fall  : combinational one-cycle edge strobes on level
// RST_VAL lets idle-high lines (scl, cs) come out of reset without a false edge.
module sync_edge_detect #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic arstn,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_target_interface.sv
// SPI mode 3 target endpoint. Oversamples scl/cs/mosi in the clk domain,
// deserialises mosi into bytes and serialises a bus-supplied byte onto miso.
//   clk, arstn      : system clock (>= 8x scl), asynchronous active-low reset
//   scl, cs, mosi   : SPI pins from the master (cs active-low)
//   miso, miso_oe   : serial data to the master and its output enable
//   bus (slave)     : tx_byte/msb_lsb in, tx_latched/rx_byte/rx_valid/busy out
module spi_target_interface
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    arstn,
    input  logic                    scl,
    input  logic                    cs,
    input  logic                    mosi,
    output logic                    miso,
    output logic                    miso_oe,
    spi_target_interface_if.slave   bus
);

    logic scl_level, scl_rise, scl_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    sync_edge_detect #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (CPOL)
    ) u_scl_sync (
        .clk   (clk),
        .arstn (arstn),
        .d     (scl),
        .level (scl_level),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    sync_edge_detect #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_cs_sync (
        .clk   (clk),
        .arstn (arstn),
        .d     (cs),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // Same depth as scl so the mosi/scl alignment seen at the pins is preserved.
    sync_edge_detect #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_mosi_sync (
        .clk   (clk),
        .arstn (arstn),
        .d     (mosi),
        .level (mosi_level),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    spi_state_e        state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [BYTE_W-1:0] tx_sr_q;
    logic [BYTE_W-1:0] rx_sr_q;
    logic [BYTE_W-1:0] rx_next;
    logic              msb_first_q;
    logic              miso_q;
    logic              miso_oe_q;
    logic              busy_q;
    logic [BYTE_W-1:0] rx_byte_q;
    logic              rx_valid_q;
    logic              tx_latched_q;

    // rx shift register with the current mosi bit merged in; used both for the
    // per-bit update and for the completed byte on the 8th rising edge.
    always_comb begin
        rx_next = rx_sr_q;
        rx_next[bit_index(bit_cnt_q, msb_first_q)] = mosi_level;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            tx_sr_q      <= '0;
            rx_sr_q      <= '0;
            msb_first_q  <= 1'b0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            busy_q       <= 1'b0;
            rx_byte_q    <= '0;
            rx_valid_q   <= 1'b0;
            tx_latched_q <= 1'b0;
        end else begin
            rx_valid_q   <= 1'b0;
            tx_latched_q <= 1'b0;
            busy_q       <= ~cs_level;
            miso_oe_q    <= ~cs_level;

            unique case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_q      <= StShift;
                        tx_sr_q      <= bus.tx_byte;
                        msb_first_q  <= bus.msb_lsb;
                        tx_latched_q <= 1'b1;
                        bit_cnt_q    <= '0;
                    end
                end
                StShift: begin
                    // cs rise wins over any coincident scl edge.
                    if (cs_rise) begin
                        state_q   <= StIdle;
                        bit_cnt_q <= '0;
                        rx_sr_q   <= '0;
                        miso_q    <= 1'b0;
                    end else if (scl_fall) begin
                        miso_q <= tx_sr_q[bit_index(bit_cnt_q, msb_first_q)];
                    end else if (scl_rise) begin
                        rx_sr_q   <= rx_next;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
                            rx_byte_q    <= rx_next;
                            rx_valid_q   <= 1'b1;
                            tx_sr_q      <= bus.tx_byte;
                            msb_first_q  <= bus.msb_lsb;
                            tx_latched_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign miso           = miso_q;
    assign miso_oe        = miso_oe_q;
    assign bus.busy       = busy_q;
    assign bus.rx_byte    = rx_byte_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.tx_latched = tx_latched_q;

endmodule

// File: tb/tb_spi_target_interface.sv
module tb_spi_target_interface;

    localparam int H = 8;  // scl half-period in clk cycles

    logic clk = 1'b0;
    logic arstn = 1'b0;
    logic scl = 1'b1;
    logic cs = 1'b1;
    logic mosi = 1'b0;
    logic miso;
    logic miso_oe;

    spi_target_interface_if bus ();

    spi_target_interface #(
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .arstn   (arstn),
        .scl     (scl),
        .cs      (cs),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int n_rxv = 0;
    int n_txl = 0;
    logic [7:0] exp_q[$];

    // Scoreboard: every rx_valid pops the oldest expected byte.
    always @(negedge clk) begin
        logic [7:0] e;
        if (bus.tx_latched) n_txl++;
        if (bus.rx_valid) begin
            n_rxv++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL rx_unexpected: got %02h want no byte", bus.rx_byte);
            end else begin
                e = exp_q.pop_front();
                if (bus.rx_byte !== e)
                    $display("FAIL rx_byte_sb: got %02h want %02h", bus.rx_byte, e);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master side of nbits of mode-3 transfer; seq holds miso bits in time order.
    task automatic spi_xfer(input logic [7:0] tx_b, input int nbits, input logic msb_first,
                            output logic [7:0] seq);
        seq = '0;
        for (int i = 0; i < nbits; i++) begin
            scl  = 1'b0;
            mosi = msb_first ? tx_b[7-i] : tx_b[i];
            wait_clk(H);
            scl = 1'b1;
            seq = {seq[6:0], miso};
            wait_clk(H);
        end
    endtask

    task automatic test_reset;
        arstn = 1'b0;
        wait_clk(3);
        #1;
        n_checks++; if (miso !== 1'b0) $display("FAIL rst_miso: got %b want 0", miso); else n_pass++;
        n_checks++; if (miso_oe !== 1'b0) $display("FAIL rst_miso_oe: got %b want 0", miso_oe); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.rx_byte !== 8'h00) $display("FAIL rst_rx_byte: got %02h want 00", bus.rx_byte); else n_pass++;
        n_checks++; if (bus.rx_valid !== 1'b0) $display("FAIL rst_rx_valid: got %b want 0", bus.rx_valid); else n_pass++;
        n_checks++; if (bus.tx_latched !== 1'b0) $display("FAIL rst_tx_latched: got %b want 0", bus.tx_latched); else n_pass++;
        arstn = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_msb_first;
        logic [7:0] seq;
        int rxv0, txl0;
        rxv0 = n_rxv; txl0 = n_txl;
        bus.msb_lsb = 1'b1;
        bus.tx_byte = 8'h3C;
        exp_q.push_back(8'hA5);
        cs = 1'b0;
        wait_clk(H);
        n_checks++; if (bus.busy !== 1'b1 || miso_oe !== 1'b1)
            $display("FAIL msb_busy_oe: got %b%b want 11", bus.busy, miso_oe); else n_pass++;
        spi_xfer(8'hA5, 8, 1'b1, seq);
        cs = 1'b1;
        wait_clk(H);
        n_checks++; if (seq !== 8'h3C) $display("FAIL msb_miso: got %02h want 3c", seq); else n_pass++;
        n_checks++; if (n_rxv - rxv0 != 1) $display("FAIL msb_rxv_cnt: got %0d want 1", n_rxv - rxv0); else n_pass++;
        n_checks++; if (n_txl - txl0 != 2) $display("FAIL msb_txl_cnt: got %0d want 2", n_txl - txl0); else n_pass++;
        n_checks++; if (bus.rx_byte !== 8'hA5) $display("FAIL msb_rx_hold: got %02h want a5", bus.rx_byte); else n_pass++;
    endtask

    task automatic test_lsb_first;
        logic [7:0] seq;
        bus.msb_lsb = 1'b0;
        bus.tx_byte = 8'h80;
        exp_q.push_back(8'h01);
        cs = 1'b0;
        wait_clk(H);
        spi_xfer(8'h01, 8, 1'b0, seq);
        cs = 1'b1;
        wait_clk(H);
        n_checks++; if (seq !== 8'b0000_0001) $display("FAIL lsb_miso_seq: got %b want 00000001", seq); else n_pass++;
        n_checks++; if (bus.rx_byte !== 8'h01) $display("FAIL lsb_rx: got %02h want 01", bus.rx_byte); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] seq0, seq1;
        int rxv0;
        logic seen;
        rxv0 = n_rxv;
        bus.msb_lsb = 1'b1;
        bus.tx_byte = 8'h11;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        cs = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.tx_latched) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b1) $display("FAIL b2b_first_latch: got %b want 1", seen); else n_pass++;
        bus.tx_byte = 8'h56;
        wait_clk(H);
        spi_xfer(8'h12, 8, 1'b1, seq0);
        spi_xfer(8'h34, 8, 1'b1, seq1);
        cs = 1'b1;
        wait_clk(H);
        n_checks++; if (seq0 !== 8'h11) $display("FAIL b2b_miso0: got %02h want 11", seq0); else n_pass++;
        n_checks++; if (seq1 !== 8'h56) $display("FAIL b2b_miso1: got %02h want 56", seq1); else n_pass++;
        n_checks++; if (n_rxv - rxv0 != 2) $display("FAIL b2b_rxv_cnt: got %0d want 2", n_rxv - rxv0); else n_pass++;
    endtask

    task automatic test_abort;
        logic [7:0] seq;
        int rxv0, txl0;
        rxv0 = n_rxv; txl0 = n_txl;
        bus.msb_lsb = 1'b1;
        bus.tx_byte = 8'hFF;
        cs = 1'b0;
        wait_clk(H);
        spi_xfer(8'hE7, 4, 1'b1, seq);
        cs = 1'b1;
        wait_clk(H);
        n_checks++; if (n_rxv != rxv0) $display("FAIL abort_rxv: got %0d want 0", n_rxv - rxv0); else n_pass++;
        n_checks++; if (n_txl - txl0 != 1) $display("FAIL abort_txl: got %0d want 1", n_txl - txl0); else n_pass++;
        n_checks++; if (bus.rx_byte !== 8'h34) $display("FAIL abort_rx_hold: got %02h want 34", bus.rx_byte); else n_pass++;
        n_checks++; if (miso !== 1'b0) $display("FAIL abort_miso: got %b want 0", miso); else n_pass++;
        exp_q.push_back(8'hFF);
        cs = 1'b0;
        wait_clk(H);
        spi_xfer(8'hFF, 8, 1'b1, seq);
        cs = 1'b1;
        wait_clk(H);
        n_checks++; if (bus.rx_byte !== 8'hFF) $display("FAIL abort_next_rx: got %02h want ff", bus.rx_byte); else n_pass++;
        n_checks++; if (seq !== 8'hFF) $display("FAIL abort_next_miso: got %02h want ff", seq); else n_pass++;
    endtask

    task automatic test_idle_scl;
        int rxv0, txl0;
        logic act;
        rxv0 = n_rxv; txl0 = n_txl;
        act = 1'b0;
        for (int i = 0; i < 16; i++) begin
            scl  = ~scl;
            mosi = i[1];
            wait_clk(H);
            if (bus.busy !== 1'b0 || miso_oe !== 1'b0) act = 1'b1;
        end
        wait_clk(4);
        n_checks++; if (act !== 1'b0) $display("FAIL idle_busy_oe: got %b want 0", act); else n_pass++;
        n_checks++; if (n_rxv != rxv0) $display("FAIL idle_rxv: got %0d want 0", n_rxv - rxv0); else n_pass++;
        n_checks++; if (n_txl != txl0) $display("FAIL idle_txl: got %0d want 0", n_txl - txl0); else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [7:0] seq;
        bus.msb_lsb = 1'b1;
        bus.tx_byte = 8'h5A;
        cs = 1'b0;
        wait_clk(H);
        spi_xfer(8'h99, 5, 1'b1, seq);
        arstn = 1'b0;
        cs = 1'b1;
        scl = 1'b1;
        #1;
        n_checks++; if ({miso, miso_oe, bus.busy, bus.rx_valid, bus.tx_latched} !== 5'b0)
            $display("FAIL rstmid_flags: got %b want 00000",
                     {miso, miso_oe, bus.busy, bus.rx_valid, bus.tx_latched}); else n_pass++;
        n_checks++; if (bus.rx_byte !== 8'h00) $display("FAIL rstmid_rx: got %02h want 00", bus.rx_byte); else n_pass++;
        wait_clk(2);
        arstn = 1'b1;
        wait_clk(4);
        exp_q.push_back(8'hC3);
        cs = 1'b0;
        wait_clk(H);
        spi_xfer(8'hC3, 8, 1'b1, seq);
        cs = 1'b1;
        wait_clk(H);
        n_checks++; if (bus.rx_byte !== 8'hC3) $display("FAIL rstmid_next_rx: got %02h want c3", bus.rx_byte); else n_pass++;
        n_checks++; if (seq !== 8'h5A) $display("FAIL rstmid_next_miso: got %02h want 5a", seq); else n_pass++;
    endtask

    initial begin
        bus.tx_byte = 8'h00;
        bus.msb_lsb = 1'b1;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_abort();
        test_idle_scl();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL sb_drain: got %0d want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
